// File: rtl/key_press_gen_if.sv
// key_press_gen_if: trigger/abort request and key line/status handshake for key_press_gen.
interface key_press_gen_if;
    logic trig;
    logic abort;
    logic key_out;
    logic busy;
    logic done;
    modport master(output trig, abort, input key_out, busy, done);
    modport slave(input trig, abort, output key_out, busy, done);
endinterface

// File: rtl/key_press_gen.sv
// key_press_gen: emulated active-low push-button (press bounce, hold, release bounce).
// Define KEY_GEN_BOUNCE_EN to enable LFSR-driven random toggling inside the bounce windows.
module key_press_gen #(
    parameter logic [23:0] BOUNCE_CNT = 24'd250_000,
    parameter logic [23:0] HOLD_CNT   = 24'd2_500_000,
    parameter int          IV_W       = 12,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    key_press_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;
    state_t state, state_n;
    logic key, key_n, busy, busy_n, done, done_n;
    logic [23:0] win_cnt, win_n, hold_cnt, hold_n;
    logic [15:0] lfsr, lfsr_n;
`ifdef KEY_GEN_BOUNCE_EN
    logic [IV_W-1:0] iv, iv_n;
`endif
    assign bus.key_out = key;
    assign bus.busy = busy;
    assign bus.done = done;
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            key <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            win_cnt <= '0;
            hold_cnt <= '0;
            lfsr <= LFSR_SEED;
`ifdef KEY_GEN_BOUNCE_EN
            iv <= '0;
`endif
        end else begin
            state <= state_n;
            key <= key_n;
            busy <= busy_n;
            done <= done_n;
            win_cnt <= win_n;
            hold_cnt <= hold_n;
            lfsr <= lfsr_n;
`ifdef KEY_GEN_BOUNCE_EN
            iv <= iv_n;
`endif
        end
    end
    always_comb begin
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        state_n = state;
        key_n = key;
        busy_n = busy;
        done_n = 1'b0;
        win_n = win_cnt;
        hold_n = hold_cnt;
`ifdef KEY_GEN_BOUNCE_EN
        iv_n = iv;
`endif
        case (state)
            IDLE: begin
                key_n = 1'b1;
                busy_n = 1'b0;
                if (bus.trig && !bus.abort) begin
                    state_n = PRESS_B;
                    key_n = 1'b0;
                    busy_n = 1'b1;
                    win_n = '0;
`ifdef KEY_GEN_BOUNCE_EN
                    iv_n = lfsr[IV_W-1:0];
`endif
                end
            end
            PRESS_B, REL_B: begin
`ifdef KEY_GEN_BOUNCE_EN
                if (iv == '0) begin
                    key_n = ~key;
                    iv_n = lfsr[IV_W-1:0];
                end else begin
                    iv_n = iv - 1'b1;
                end
`endif
                win_n = win_cnt + 24'd1;
                // window end forces the settled level, overriding any toggle this cycle
                if (win_cnt == BOUNCE_CNT - 24'd1) begin
                    state_n = (state == PRESS_B) ? HOLD : IDLE;
                    key_n = (state == REL_B);
                    busy_n = (state == PRESS_B);
                    done_n = (state == REL_B);
                    hold_n = '0;
                end
            end
            HOLD: begin
                key_n = 1'b0;
                hold_n = hold_cnt + 24'd1;
                if (hold_cnt == HOLD_CNT - 24'd1) begin
                    state_n = REL_B;
                    key_n = 1'b1;
                    win_n = '0;
`ifdef KEY_GEN_BOUNCE_EN
                    iv_n = lfsr[IV_W-1:0];
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            key_n = 1'b1;
            busy_n = 1'b0;
            done_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_key_press_gen.sv
// tb_key_press_gen: directed checks of key_press_gen with BOUNCE_CNT=16, HOLD_CNT=40, IV_W=2.
// Trace index 0 is the first negedge after the edge that samples trig.
module tb_key_press_gen;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic key_tr [0:199];
    logic busy_tr [0:199];
    logic done_tr [0:199];
    logic ref_key [0:99];
    key_press_gen_if bus();
    key_press_gen #(
        .BOUNCE_CNT(24'd16),
        .HOLD_CNT(24'd40),
        .IV_W(2),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_trace(input int len, input int trig_at, input int abort_at, input int rst_at);
        @(negedge sys_clk);
        bus.trig = 1'b1;
        @(negedge sys_clk);
        bus.trig = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge sys_clk);
            key_tr[i] = bus.key_out;
            busy_tr[i] = bus.busy;
            done_tr[i] = bus.done;
            bus.trig = (i == trig_at);
            bus.abort = (i == abort_at);
            sys_rst_n = !(i == rst_at);
        end
        bus.trig = 1'b0;
        bus.abort = 1'b0;
        sys_rst_n = 1'b1;
    endtask

    task automatic analyze(input string tag);
        int busy_cnt = 0, done_cnt = 0, done_at = -1, hold_hi = 0, tail_lo = 0;
        int press_tog = 0, rel_tog = 0, max_gap = 0, last = 0, falls = 0, rises = 0, rise_at = -1;
        logic prev = 1'b1;
        for (int i = 0; i < 100; i++) begin
            busy_cnt += int'(busy_tr[i]);
            if (done_tr[i]) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i >= 16 && i <= 55) hold_hi += int'(key_tr[i]);
            if (i >= 72) tail_lo += int'(!key_tr[i]);
            if (prev && !key_tr[i]) falls++;
            if (!prev && key_tr[i]) begin
                rises++;
                if (rise_at < 0) rise_at = i;
            end
            if (i == 0 || i == 56) last = i;
            if ((i >= 1 && i <= 15) || (i >= 57 && i <= 71)) begin
                if (key_tr[i] != key_tr[i-1]) begin
                    if (i <= 15) press_tog++; else rel_tog++;
                    if (i - last > max_gap) max_gap = i - last;
                    last = i;
                end
            end
            prev = key_tr[i];
        end
        check({tag, "_key0"}, key_tr[0], 0);
        check({tag, "_busy0"}, busy_tr[0], 1);
        check({tag, "_busy_len"}, busy_cnt, 72);
        check({tag, "_busy_end"}, busy_tr[72], 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, 72);
        check({tag, "_hold_low"}, hold_hi, 0);
        check({tag, "_key_after"}, tail_lo, 0);
`ifdef KEY_GEN_BOUNCE_EN
        check({tag, "_press_tog"}, press_tog > 0, 1);
        check({tag, "_rel_tog"}, rel_tog > 0, 1);
        check({tag, "_gap"}, max_gap >= 1 && max_gap <= 4, 1);
`else
        check({tag, "_falls"}, falls, 1);
        check({tag, "_rises"}, rises, 1);
        check({tag, "_rise_at"}, rise_at, 56);
        check({tag, "_no_tog"}, press_tog + rel_tog, 0);
`endif
    endtask

    initial begin
        int diff, d0, d1, n;
        bus.trig = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst_key", bus.key_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        sys_rst_n = 1'b1;
        run_trace(100, -1, -1, -1);
        analyze("basic");
        for (int i = 0; i < 100; i++) ref_key[i] = key_tr[i];
        run_trace(100, 20, -1, -1);
        analyze("trig_busy");
        run_trace(100, -1, 30, -1);
        check("abort_busy_before", busy_tr[30], 1);
        check("abort_key", key_tr[31], 1);
        check("abort_busy", busy_tr[31], 0);
        diff = 0;
        for (int i = 0; i < 100; i++) diff += int'(done_tr[i]);
        check("abort_no_done", diff, 0);
        run_trace(100, -1, -1, -1);
        analyze("post_abort");
        run_trace(62, -1, -1, 60);
        check("mid_rst_busy_before", busy_tr[60], 1);
        check("mid_rst_key", key_tr[61], 1);
        check("mid_rst_busy", busy_tr[61], 0);
        check("mid_rst_done", done_tr[61], 0);
        run_trace(100, -1, -1, -1);
        analyze("post_rst");
        diff = 0;
        for (int i = 0; i < 100; i++) diff += int'(key_tr[i] !== ref_key[i]);
        check("repro", diff, 0);
        @(negedge sys_clk);
        bus.trig = 1'b1;
        d0 = -1;
        d1 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (bus.done) begin
                if (d0 < 0) d0 = i;
                else if (d1 < 0) d1 = i;
            end
        end
        bus.trig = 1'b0;
        check("held_two_done", d0 >= 0 && d1 >= 0, 1);
        check("held_spacing", d1 - d0, 73);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        check("drain_idle", bus.busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
